// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing cells.
//   launch_state_t   : handshake state of the source-side launcher
//   DefaultNumStages : default synchronizer depth
//   cnt_width()      : width of a counter that must hold 0..limit
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } launch_state_t;

  localparam int unsigned DefaultNumStages = 2;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer.
//   CLK : destination clock
//   RST : asynchronous active-low reset, clears every stage
//   d   : asynchronous input
//   q   : input after NUM_STAGES flops
module bit_sync
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DefaultNumStages
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], d};
    end
  end

  assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_launch.sv
// Source-domain launcher of the multi-bit bus synchronizer. Holds an accepted
// word on Unsync_bus and runs a 4-phase req/ack handshake so the word never
// changes while the destination may still be sampling it.
//   CLK, RST     : source clock, asynchronous active-low reset
//   src_valid    : word offered on src_data
//   src_data     : word to transmit
//   src_ready    : launcher idle, can accept a word
//   Unsync_bus   : held word toward the destination synchronizer
//   bus_enable   : request level toward the destination
//   dst_ack      : acknowledge from the destination (asynchronous)
//   xfer_done    : one-cycle pulse on normal handshake completion
//   err_timeout  : sticky flag, a handshake phase exceeded TIMEOUT cycles
//   err_clr      : clears err_timeout (a coincident new timeout wins)
module data_sync_launch
  import cdc_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_STAGES = DefaultNumStages,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 src_valid,
  input  logic [BUS_WIDTH-1:0] src_data,
  output logic                 src_ready,
  output logic [BUS_WIDTH-1:0] Unsync_bus,
  output logic                 bus_enable,
  input  logic                 dst_ack,
  output logic                 xfer_done,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  logic                 ack_s;
  launch_state_t        state_q;
  logic [BUS_WIDTH-1:0] bus_q;
  logic                 enable_q;
  logic                 done_q;
  logic                 err_q;
  // Set when the current transfer left REQ by timeout; its REL exit is not
  // a normal completion and must not pulse xfer_done.
  logic                 abort_q;
  logic                 to_hit;
  logic                 leave;
  logic                 err_set;

  // The only sampling point of dst_ack.
  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (dst_ack),
    .q  (ack_s)
  );

  // State is about to change this cycle; the phase counter restarts.
  always_comb begin
    leave = 1'b0;
    case (state_q)
      REQ:     leave = ack_s | to_hit;
      REL:     leave = ~ack_s | to_hit;
      default: leave = 1'b0;
    endcase
  end

  always_comb begin
    err_set = 1'b0;
    case (state_q)
      REQ:     err_set = ~ack_s & to_hit;
      REL:     err_set = ack_s & to_hit;
      default: err_set = 1'b0;
    endcase
  end

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam int unsigned CntW = cnt_width(TIMEOUT);
      logic [CntW-1:0] cnt_q;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          cnt_q <= '0;
        end else if (state_q == IDLE || leave) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end

      // Fires on the cycle whose increment would reach TIMEOUT, so a phase
      // lasts at most TIMEOUT cycles.
      assign to_hit = (state_q != IDLE) && (cnt_q == CntW'(TIMEOUT - 1));
    end else begin : g_no_cnt
      assign to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      bus_q    <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // A stale ack_s here is ignored; launch regardless.
          if (src_valid) begin
            bus_q    <= src_data;
            enable_q <= 1'b1;
            abort_q  <= 1'b0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            enable_q <= 1'b0;
            state_q  <= REL;
          end else if (to_hit) begin
            enable_q <= 1'b0;
            abort_q  <= 1'b1;
            state_q  <= REL;
          end
        end
        REL: begin
          if (!ack_s) begin
            done_q  <= ~abort_q;
            state_q <= IDLE;
          end else if (to_hit) begin
            state_q <= IDLE;
          end
        end
        default: begin
          enable_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign src_ready   = (state_q == IDLE);
  assign Unsync_bus  = bus_q;
  assign bus_enable  = enable_q;
  assign xfer_done   = done_q;
  assign err_timeout = err_q;

endmodule
